// File: rtl/cic_feed_ctrl.sv
// cic_feed_ctrl
// Rate/strobe controller and sample buffer in front of the CIC interpolator.
// Audio-rate samples enter a small FIFO through a valid/ready handshake.
// A divider produces the high-rate strobe stb_out, and a phase counter
// produces the input-rate strobe stb_in once every `rate` stb_out pulses.
// On each stb_in the FIFO head is popped onto data_out. If the FIFO is
// empty at that moment, data_out is zero-filled and the sticky underrun
// flag is set.
//
// Handshake: a sample transfers on a rising clk edge where
// in_valid && in_ready. in_ready does not depend on in_valid.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   enable      block enable; low clears all state on the next edge
//   rate        interpolation ratio (0 behaves as 1)
//   clk_div     stb_out period minus 1, in clk cycles
//   in_data     upstream sample
//   in_valid    upstream sample valid
//   in_ready    FIFO can accept a sample
//   data_out    sample to interpolator, meaningful when stb_in is high
//   stb_in      input-rate strobe (always a subset of stb_out)
//   stb_out     output-rate strobe
//   level       FIFO occupancy, 0..2**FIFO_AW
//   underrun    sticky underrun flag
module cic_feed_ctrl #(
   parameter int WIDTH   = 16,
   parameter int FIFO_AW = 3,
   parameter int DIV_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [7:0]         rate,
   input  logic [DIV_W-1:0]   clk_div,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   data_out,
   output logic               stb_in,
   output logic               stb_out,
   output logic [FIFO_AW:0]   level,
   output logic               underrun
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L = DEPTH[FIFO_AW:0];

   logic [DIV_W-1:0]   div_cnt;
   logic [7:0]         phase_cnt;
   logic [7:0]         r_lat;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [WIDTH-1:0]   mem [DEPTH];

   logic       hit;
   logic       take_in;
   logic       push;
   logic       pop;
   logic [7:0] rate_eff;

   always_comb begin
      // The >= compare lets a lowered clk_div take effect at once.
      hit      = (div_cnt >= clk_div);
      rate_eff = (rate == 8'd0) ? 8'd1 : rate;
      take_in  = hit && (phase_cnt == 8'd0);
      in_ready = enable && !rst && (level < DEPTH_L);
      push     = in_valid && in_ready;
      pop      = take_in && (level != '0);
   end

   // The FIFO storage has no reset; push is already gated by enable and rst.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         div_cnt   <= '0;
         phase_cnt <= '0;
         r_lat     <= 8'd1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         underrun  <= 1'b0;
         stb_in    <= 1'b0;
         stb_out   <= 1'b0;
         data_out  <= '0;
      end else begin
         stb_out <= hit;
         stb_in  <= take_in;

         if (hit) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // The ratio is sampled at the start of each input period and held
         // until the period ends, so a rate change never cuts a period short.
         if (hit) begin
            if (phase_cnt == 8'd0) begin
               r_lat     <= rate_eff;
               phase_cnt <= (rate_eff == 8'd1) ? 8'd0 : 8'd1;
            end else if (phase_cnt == r_lat - 8'd1) begin
               phase_cnt <= 8'd0;
            end else begin
               phase_cnt <= phase_cnt + 8'd1;
            end
         end

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         // An empty FIFO zero-fills the strobe. A sample pushed on the
         // same edge is stored and not bypassed.
         if (take_in) begin
            if (pop) begin
               data_out <= mem[rd_ptr];
               rd_ptr   <= rd_ptr + 1'b1;
            end else begin
               data_out <= '0;
               underrun <= 1'b1;
            end
         end

         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule
